mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_pkg.sv | 51 +++++
 rtl/mc_alu_dec.sv | 63 ++++++
 rtl/mc_control.sv | 175 +++++++++++++++++
 tb/tb_mc_control.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: states, ALU ops, opcodes,
// funct codes and datapath mux selects.
package mc_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_MEM_WB   = 4'd6;
  localparam logic [3:0] S_MEM_WR   = 4'd7;
  localparam logic [3:0] S_WB_R     = 4'd8;
  localparam logic [3:0] S_WB_I     = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_HALT     = 4'd12;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_LUI = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

endpackage

// File: rtl/mc_alu_dec.sv
// Opcode/funct decoder: ALU op for R-type and I-type, plus legality flags.
// Optional lui support is enabled with `MC_CONTROL_LUI_EN.
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_op_r,
  output logic       o_illegal_funct,
  output logic [2:0] o_alu_op_i,
  output logic       o_expand_i,
  output logic       o_illegal_op
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    o_alu_op_r      = ALU_ADD;
    o_illegal_funct = 1'b0;
    case (i_funct)
      F_ADD:   o_alu_op_r = ALU_ADD;
      F_SUB:   o_alu_op_r = ALU_SUB;
      F_AND:   o_alu_op_r = ALU_AND;
      F_OR:    o_alu_op_r = ALU_OR;
      F_SLT:   o_alu_op_r = ALU_SLT;
      default: o_illegal_funct = 1'b1;
    endcase
  end

  always_comb begin
    o_alu_op_i = ALU_ADD;
    o_expand_i = 1'b1;
    case (i_op)
      OP_ANDI: begin
        o_alu_op_i = ALU_AND;
        o_expand_i = 1'b0;
      end
      OP_ORI: begin
        o_alu_op_i = ALU_OR;
        o_expand_i = 1'b0;
      end
`ifdef MC_CONTROL_LUI_EN
      OP_LUI: begin
        o_alu_op_i = ALU_LUI;
        o_expand_i = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    o_illegal_op = 1'b1;
    case (i_op)
      OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI,
      OP_LW, OP_SW, OP_BEQ, OP_J: o_illegal_op = 1'b0;
`ifdef MC_CONTROL_LUI_EN
      OP_LUI: o_illegal_op = 1'b0;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS-subset controller FSM; outputs decoded from state and op/funct.
// Define `MC_CONTROL_LUI_EN to make op 001111 (lui) legal.
module mc_control
  import mc_pkg::*;
#(
  parameter int ALU_OP_W        = 3,
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
  output logic                pc_we,
  output logic                ir_we,
  output logic                rf_we,
  output logic                mem_we,
  output logic                expand,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic [1:0]          pc_src,
  output logic [3:0]          state_o,
  output logic                illegal
);

  logic [3:0] r_state;
  logic       r_illegal;
  logic [3:0] w_next_state;
  logic [3:0] w_trap_state;
  logic       w_set_illegal;

  logic [2:0] w_alu_op_r;
  logic [2:0] w_alu_op_i;
  logic       w_illegal_funct;
  logic       w_illegal_op;
  logic       w_expand_i;

  logic       w_pc_we, w_ir_we, w_rf_we, w_mem_we, w_expand;
  logic [2:0] w_alu_op;

  mc_alu_dec u_alu_dec (
    .i_op            (op),
    .i_funct         (funct),
    .o_alu_op_r      (w_alu_op_r),
    .o_illegal_funct (w_illegal_funct),
    .o_alu_op_i      (w_alu_op_i),
    .o_expand_i      (w_expand_i),
    .o_illegal_op    (w_illegal_op)
  );

  assign w_trap_state = (HALT_ON_ILLEGAL != 0) ? S_HALT : S_FETCH;

  always_comb begin
    w_next_state  = r_state;
    w_set_illegal = 1'b0;
    case (r_state)
      S_FETCH: w_next_state = S_DECODE;
      S_DECODE: begin
        if (w_illegal_op) begin
          w_set_illegal = 1'b1;
          w_next_state  = w_trap_state;
        end else begin
          case (op)
            OP_RTYPE:     w_next_state = S_EXEC_R;
            OP_LW, OP_SW: w_next_state = S_MEM_ADDR;
            OP_BEQ:       w_next_state = S_BRANCH;
            OP_J:         w_next_state = S_JUMP;
            default:      w_next_state = S_EXEC_I;
          endcase
        end
      end
      S_EXEC_R: begin
        if (w_illegal_funct) begin
          w_set_illegal = 1'b1;
          w_next_state  = w_trap_state;
        end else begin
          w_next_state = S_WB_R;
        end
      end
      S_EXEC_I:   w_next_state = S_WB_I;
      S_MEM_ADDR: w_next_state = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   w_next_state = S_MEM_WB;
      S_MEM_WB, S_MEM_WR, S_WB_R, S_WB_I, S_BRANCH, S_JUMP:
                  w_next_state = S_FETCH;
      S_HALT:     w_next_state = S_HALT;
      default:    w_next_state = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_set_illegal) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_pc_we    = 1'b0;
    w_ir_we    = 1'b0;
    w_rf_we    = 1'b0;
    w_mem_we   = 1'b0;
    w_expand   = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    w_alu_op   = ALU_ADD;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = PC_SRC_ALU;
    case (r_state)
      S_FETCH: begin
        w_ir_we   = 1'b1;
        w_pc_we   = 1'b1;
        alu_src_b = SRCB_FOUR;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        w_expand  = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        w_alu_op  = w_alu_op_r;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_alu_op  = w_alu_op_i;
        w_expand  = w_expand_i;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_expand  = 1'b1;
      end
      S_MEM_WB: begin
        w_rf_we    = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: w_mem_we = 1'b1;
      S_WB_R: begin
        w_rf_we = 1'b1;
        reg_dst = 1'b1;
      end
      S_WB_I: w_rf_we = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        w_alu_op  = ALU_SUB;
        pc_src    = PC_SRC_ALUOUT;
        w_pc_we   = zero;
      end
      S_JUMP: begin
        pc_src  = PC_SRC_JUMP;
        w_pc_we = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset is FETCH, so the FETCH enables must be masked while rst is held.
  assign pc_we   = w_pc_we  & ~rst;
  assign ir_we   = w_ir_we  & ~rst;
  assign rf_we   = w_rf_we  & ~rst;
  assign mem_we  = w_mem_we & ~rst;
  assign expand  = w_expand & ~rst;
  assign alu_op  = ALU_OP_W'(w_alu_op);
  assign state_o = r_state;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: stimulus queues expected per-cycle controls,
// a negedge monitor pops and compares the masked fields.
module tb_mc_control;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, funct;
  logic       zero;
  logic       pc_we, ir_we, rf_we, mem_we, expand, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       reg_dst, mem_to_reg;
  logic [1:0] pc_src;
  logic [3:0] state_o;
  logic       illegal;

  mc_control #(.ALU_OP_W(3), .HALT_ON_ILLEGAL(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pc_we      (pc_we),
    .ir_we      (ir_we),
    .rf_we      (rf_we),
    .mem_we     (mem_we),
    .expand     (expand),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .pc_src     (pc_src),
    .state_o    (state_o),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_we, ir_we, rf_we, mem_we, expand, src_a;
    logic [1:0] src_b;
    logic [2:0] alu;
    logic       reg_dst, m2r;
    logic [1:0] pc_src;
    logic       ill;
  } ctrl_t;

  ctrl_t q_val[$];
  ctrl_t q_mask[$];
  string q_name[$];

  int checks = 0;
  int passes = 0;

  ctrl_t cv, cm;
  string cn;
  logic  exp_ill = 1'b0;

  // Monitor: one comparison per queued expectation, sampled mid-cycle.
  always @(negedge clk) begin
    ctrl_t v, m, a;
    string n;
    if (q_val.size() != 0) begin
      v = q_val.pop_front();
      m = q_mask.pop_front();
      n = q_name.pop_front();
      a = {state_o, pc_we, ir_we, rf_we, mem_we, expand, alu_src_a,
           alu_src_b, alu_op, reg_dst, mem_to_reg, pc_src, illegal};
      checks++;
      if (((a ^ v) & m) != '0)
        $display("FAIL %s: got %h expected %h (mask %h)", n, a, v, m);
      else
        passes++;
    end
  end

  task automatic push();
    q_val.push_back(cv);
    q_mask.push_back(cm);
    q_name.push_back(cn);
  endtask

  task automatic step();
    push();
    @(posedge clk);
    #1;
  endtask

  // Every entry checks state, all write enables and the sticky illegal flag.
  task automatic begin_exp(input string n, input logic [3:0] st);
    cn = n;
    cv = '0;
    cm = '0;
    cv.st = st;   cm.st = '1;
    cm.pc_we = 1'b1; cm.ir_we = 1'b1; cm.rf_we = 1'b1; cm.mem_we = 1'b1;
    cv.ill = exp_ill; cm.ill = 1'b1;
  endtask

  task automatic s_fetch(input string t);
    begin_exp({t, "/fetch"}, S_FETCH);
    cv.pc_we = 1'b1; cv.ir_we = 1'b1;
    cm.src_a = 1'b1; cv.src_b = 2'd1; cm.src_b = '1;
    cm.alu = '1; cm.pc_src = '1;
    step();
  endtask

  task automatic s_decode(input string t);
    begin_exp({t, "/decode"}, S_DECODE);
    cm.src_a = 1'b1; cv.src_b = 2'd3; cm.src_b = '1;
    cm.alu = '1; cv.expand = 1'b1; cm.expand = 1'b1;
    step();
  endtask

  task automatic s_exec_r(input string t, input logic [2:0] a, input logic chk_alu);
    begin_exp({t, "/exec_r"}, S_EXEC_R);
    cv.src_a = 1'b1; cm.src_a = 1'b1; cm.src_b = '1;
    cv.alu = a; cm.alu = chk_alu ? 3'b111 : 3'b000;
    step();
  endtask

  task automatic s_exec_i(input string t, input logic [2:0] a, input logic ex);
    begin_exp({t, "/exec_i"}, S_EXEC_I);
    cv.src_a = 1'b1; cm.src_a = 1'b1; cv.src_b = 2'd2; cm.src_b = '1;
    cv.alu = a; cm.alu = '1; cv.expand = ex; cm.expand = 1'b1;
    step();
  endtask

  task automatic s_mem_addr(input string t);
    begin_exp({t, "/mem_addr"}, S_MEM_ADDR);
    cv.src_a = 1'b1; cm.src_a = 1'b1; cv.src_b = 2'd2; cm.src_b = '1;
    cm.alu = '1; cv.expand = 1'b1; cm.expand = 1'b1;
    step();
  endtask

  task automatic s_mem_wb(input string t);
    begin_exp({t, "/mem_wb"}, S_MEM_WB);
    cv.rf_we = 1'b1; cm.reg_dst = 1'b1; cv.m2r = 1'b1; cm.m2r = 1'b1;
    step();
  endtask

  task automatic s_wb(input string t, input logic r);
    begin_exp({t, r ? "/wb_r" : "/wb_i"}, r ? S_WB_R : S_WB_I);
    cv.rf_we = 1'b1; cv.reg_dst = r; cm.reg_dst = 1'b1; cm.m2r = 1'b1;
    step();
  endtask

  task automatic s_branch(input string t, input logic z);
    begin_exp({t, "/branch"}, S_BRANCH);
    cv.pc_we = z; cv.src_a = 1'b1; cm.src_a = 1'b1; cm.src_b = '1;
    cv.alu = 3'd1; cm.alu = '1; cv.pc_src = 2'd1; cm.pc_src = '1;
    step();
  endtask

  task automatic s_simple(input string n, input logic [3:0] st);
    begin_exp(n, st);
    if (st == S_MEM_WR) cv.mem_we = 1'b1;
    if (st == S_JUMP) begin
      cv.pc_we = 1'b1; cv.pc_src = 2'd2; cm.pc_src = '1;
    end
    step();
  endtask

  // Holds rst across two rising edges; the expectation lands on a negedge with rst high.
  task automatic do_reset();
    rst = 1'b1;
    exp_ill = 1'b0;
    begin_exp("reset", S_FETCH);
    cm.expand = 1'b1;
    push();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_in(input logic [5:0] o, input logic [5:0] f, input logic z);
    op = o; funct = f; zero = z;
  endtask

  logic [5:0] r_functs [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] r_alus   [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};

  initial begin
    rst = 1'b0;
    set_in(6'b000000, 6'b000000, 1'b0);
    #1;
    do_reset();

    set_in(6'b100011, 6'b000000, 1'b0);
    s_fetch("lw"); s_decode("lw"); s_mem_addr("lw");
    s_simple("lw/mem_rd", S_MEM_RD); s_mem_wb("lw");

    set_in(6'b101011, 6'b000000, 1'b0);
    s_fetch("sw"); s_decode("sw"); s_mem_addr("sw"); s_simple("sw/mem_wr", S_MEM_WR);

    set_in(6'b001101, 6'b000000, 1'b0);
    s_fetch("ori"); s_decode("ori"); s_exec_i("ori", 3'd3, 1'b0); s_wb("ori", 1'b0);

    set_in(6'b001000, 6'b000000, 1'b0);
    s_fetch("addi"); s_decode("addi"); s_exec_i("addi", 3'd0, 1'b1); s_wb("addi", 1'b0);

    set_in(6'b001100, 6'b000000, 1'b0);
    s_fetch("andi"); s_decode("andi"); s_exec_i("andi", 3'd2, 1'b0); s_wb("andi", 1'b0);

    for (int i = 0; i < 5; i++) begin
      set_in(6'b000000, r_functs[i], 1'b0);
      s_fetch("rtype"); s_decode("rtype"); s_exec_r("rtype", r_alus[i], 1'b1); s_wb("rtype", 1'b1);
    end

    set_in(6'b000100, 6'b000000, 1'b1);
    s_fetch("beq_z1"); s_decode("beq_z1"); s_branch("beq_z1", 1'b1);
    set_in(6'b000100, 6'b000000, 1'b0);
    s_fetch("beq_z0"); s_decode("beq_z0"); s_branch("beq_z0", 1'b0);

    set_in(6'b000010, 6'b000000, 1'b0);
    s_fetch("j"); s_decode("j"); s_simple("j/jump", S_JUMP);

    // Reset in the middle of MEM_RD must abort the load with no register write.
    set_in(6'b100011, 6'b000000, 1'b0);
    s_fetch("lw_abort"); s_decode("lw_abort"); s_mem_addr("lw_abort");
    begin_exp("lw_abort/mem_rd", S_MEM_RD);
    push();
    @(negedge clk);
    #1;
    do_reset();
    set_in(6'b000010, 6'b000000, 1'b0);
    s_fetch("after_abort"); s_decode("after_abort"); s_simple("after_abort/jump", S_JUMP);

    set_in(6'b000000, 6'b000000, 1'b0);
    s_fetch("bad_funct"); s_decode("bad_funct"); s_exec_r("bad_funct", 3'd0, 1'b0);
    exp_ill = 1'b1;
    repeat (3) s_simple("bad_funct/halt", S_HALT);
    do_reset();

    set_in(6'b111111, 6'b000000, 1'b0);
    s_fetch("bad_op"); s_decode("bad_op");
    exp_ill = 1'b1;
    repeat (20) s_simple("bad_op/halt", S_HALT);
    do_reset();

    set_in(6'b001111, 6'b000000, 1'b0);
    s_fetch("lui"); s_decode("lui");
`ifdef MC_CONTROL_LUI_EN
    s_exec_i("lui", 3'd5, 1'b0); s_wb("lui", 1'b0);
    s_fetch("lui_next");
`else
    exp_ill = 1'b1;
    repeat (3) s_simple("lui/halt", S_HALT);
    do_reset();
    set_in(6'b000010, 6'b000000, 1'b0);
    s_fetch("lui_next");
`endif

    for (int i = 0; i < 10 && q_val.size() != 0; i++) @(posedge clk);
    if (q_val.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending expectations, required 0", q_val.size());
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
